cacheline_arbiter: RTL and testbench

Shares the single 256-bit physical-memory port (cacheline adaptor side) between the instruction-side and data-side pipelined caches. It uses a three-state FSM with round-robin tie-breaking. Each granted transaction's address, write data and command are latched for the whole transaction, and `pmem_resp` is returned only to the granted cache. It sits between the two caches' `pmem_*` ports and the cacheline adaptor.

---
 rtl/rv32i_types.sv | 16 +
 rtl/cacheline_arbiter_control.sv | 47 ++++
 rtl/cacheline_arbiter.sv | 93 +++++++++
 tb/tb_cacheline_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the memory-side arbiter: FSM states, requester sides and
// the round-robin pick used when both caches want the physical port.
package rv32i_types;

    typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D} arb_state_t;
    typedef enum logic {ARB_I, ARB_D} arb_side_t;

    // A tie goes to whichever side was not served last.
    function automatic arb_side_t arb_pick(input logic i_req, input logic d_req,
                                           input arb_side_t last_grant);
        if (i_req && d_req)
            return (last_grant == ARB_I) ? ARB_D : ARB_I;
        return d_req ? ARB_D : ARB_I;
    endfunction

endpackage

// File: rtl/cacheline_arbiter_control.sv
// Arbitration FSM: decides which cache owns the physical-memory port and
// tracks the last grant for round-robin fairness.
module cacheline_arbiter_control
    import rv32i_types::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_req,
    input  logic      d_req,
    input  logic      pmem_resp,
    output logic      grant_load,
    output arb_side_t grant_side,
    output logic      busy
);

    arb_state_t state;
    arb_side_t  last_grant;
    arb_side_t  pick;

    assign pick       = arb_pick(i_req, d_req, last_grant);
    assign busy       = (state != ARB_IDLE);
    assign grant_load = !busy && (i_req || d_req);
    // While serving, last_grant is by construction the side being served.
    assign grant_side = busy ? last_grant : pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= ARB_I;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_load) begin
                        state      <= (pick == ARB_D) ? ARB_SERVE_D : ARB_SERVE_I;
                        last_grant <= pick;
                    end
                end
                ARB_SERVE_I, ARB_SERVE_D: begin
                    if (pmem_resp)
                        state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares the 256-bit physical-memory port between the I-cache and D-cache.
// The granted command/address/data are held in registers for the whole transaction.
module cacheline_arbiter
    import rv32i_types::*;
#(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [s_addr-1:0] i_pmem_address,
    output logic              i_pmem_resp,
    output logic [s_line-1:0] i_pmem_rdata,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_addr-1:0] d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [s_line-1:0] d_pmem_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [s_addr-1:0] pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [s_line-1:0] pmem_rdata
);

    logic              i_req;
    logic              d_req;
    logic              grant_load;
    logic              busy;
    arb_side_t         grant_side;

    logic              cmd_read;
    logic              cmd_write;
    logic [s_addr-1:0] addr_q;
    logic [s_line-1:0] wdata_q;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    cacheline_arbiter_control u_control (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .d_req      (d_req),
        .pmem_resp  (pmem_resp),
        .grant_load (grant_load),
        .grant_side (grant_side),
        .busy       (busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else if (grant_load) begin
            if (grant_side == ARB_D) begin
                // A simultaneous read+write issues the writeback first; the read stays pending.
                cmd_write <= d_pmem_write;
                cmd_read  <= ~d_pmem_write;
                addr_q    <= d_pmem_address;
                wdata_q   <= d_pmem_wdata;
            end else begin
                cmd_write <= 1'b0;
                cmd_read  <= 1'b1;
                addr_q    <= i_pmem_address;
                wdata_q   <= '0;
            end
        end else if (busy && pmem_resp) begin
            cmd_read  <= 1'b0;
            cmd_write <= 1'b0;
        end
    end

    assign pmem_read    = cmd_read;
    assign pmem_write   = cmd_write;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Only the completion pulse is steered; read data goes to both caches.
    assign i_pmem_resp  = busy && pmem_resp && (grant_side == ARB_I);
    assign d_pmem_resp  = busy && pmem_resp && (grant_side == ARB_D);
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: stimulus queues expected adaptor
// transactions and cache responses, a negedge monitor pops and compares them.
module tb_cacheline_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic         i_pmem_resp;
    logic [255:0] i_pmem_rdata;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic         d_pmem_resp;
    logic [255:0] d_pmem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;

    always #5 clk = ~clk;

    cacheline_arbiter #(.s_line(256), .s_addr(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        int           cyc;
    } txn_t;

    typedef struct {
        logic         d_side;
        logic [255:0] rdata;
        int           cyc;
    } rsp_t;

    txn_t txn_q[$];
    rsp_t rsp_q[$];

    int   cyc = 0;
    logic rst_q = 1'b0;
    logic done = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // ---------------- monitor / scoreboard ----------------
    txn_t cur;
    rsp_t r;
    logic have_cur = 1'b0;
    logic prev_strobe = 1'b0;
    logic resp_prev = 1'b0;
    logic strobe;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic hold_chk(input string name);
        chk(name, 256'({pmem_write, pmem_read, pmem_address}), 256'({cur.wr, ~cur.wr, cur.addr}));
        if (cur.wr) chk({name, "_wdata"}, pmem_wdata, cur.wdata);
    endtask

    always @(negedge clk) begin
        strobe = pmem_read | pmem_write;
        if (rst_q) begin
            chk("rst_outputs", 256'({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}), '0);
            chk("rst_addr", 256'(pmem_address), '0);
            chk("rst_wdata", pmem_wdata, '0);
            have_cur = 1'b0;
        end
        if (resp_prev) chk("gap_strobe_low", 256'(strobe), '0);
        resp_prev = 1'b0;

        if (strobe === 1'b1 && prev_strobe !== 1'b1) begin
            if (txn_q.size() == 0) begin
                chk("unexpected_strobe", 256'(strobe), '0);
            end else begin
                cur = txn_q.pop_front();
                have_cur = 1'b1;
                chk("strobe_rise_cycle", 256'(cyc), 256'(cur.cyc));
                hold_chk("txn_start");
            end
        end else if (strobe === 1'b1 && have_cur) begin
            hold_chk("txn_hold");
        end

        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
            r = rsp_q.pop_front();
            chk("resp_route", 256'({i_pmem_resp, d_pmem_resp}), 256'({~r.d_side, r.d_side}));
            chk("rdata_granted", r.d_side ? d_pmem_rdata : i_pmem_rdata, r.rdata);
            chk("rdata_other", r.d_side ? i_pmem_rdata : d_pmem_rdata, r.rdata);
            chk("strobe_at_resp", 256'(strobe), 256'(1'b1));
            resp_prev = 1'b1;
        end else if (i_pmem_resp || d_pmem_resp || pmem_resp) begin
            chk("stray_resp", 256'({i_pmem_resp, d_pmem_resp}), '0);
        end
        prev_strobe = strobe;

        if (done) begin
            chk("txn_queue_drained", 256'(txn_q.size()), '0);
            chk("resp_queue_drained", 256'(rsp_q.size()), '0);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input logic wr, input logic [31:0] addr,
                            input logic [255:0] wd, input int rise);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wd; t.cyc = rise;
        txn_q.push_back(t);
    endtask

    // Adaptor completes in cycle m with rdata rd; expect resp on one side.
    task automatic finish_txn(input logic d_side, input int m, input logic [255:0] rd);
        rsp_t e;
        while (cyc < m) step();
        pmem_resp  = 1'b1;
        pmem_rdata = rd;
        e.d_side = d_side; e.rdata = rd; e.cyc = m;
        rsp_q.push_back(e);
        step();
        pmem_resp = 1'b0;
    endtask

    // Request already applied this cycle: strobe next cycle, resp after lat cycles.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [255:0] wd,
                       input logic d_side, input int lat, input logic [255:0] rd);
        int c;
        c = cyc;
        push_txn(wr, addr, wd, c + 1);
        finish_txn(d_side, c + lat, rd);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Single I fill, adaptor answers 5 cycles after the request
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
        txn(1'b0, 32'h0000_1000, '0, 1'b0, 5, {32{8'hA5}});
        i_pmem_read = 1'b0;

        // D writeback, requester address disturbed mid-transaction
        t = cyc;
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2020; d_pmem_wdata = {8{32'h1234_5678}};
        push_txn(1'b1, 32'h0000_2020, {8{32'h1234_5678}}, t + 1);
        step(); step();
        d_pmem_address = 32'hFFFF_FFFF;
        finish_txn(1'b1, t + 4, 256'h77);
        d_pmem_write = 1'b0;

        // Reset, then both sides requesting continuously: D, I, D, I
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_3000;
        d_pmem_read = 1'b1; d_pmem_address = 32'h0000_4000;
        txn(1'b0, 32'h0000_4000, '0, 1'b1, 3, 256'h11);
        txn(1'b0, 32'h0000_3000, '0, 1'b0, 3, 256'h22);
        txn(1'b0, 32'h0000_4000, '0, 1'b1, 3, 256'h33);
        txn(1'b0, 32'h0000_3000, '0, 1'b0, 3, 256'h44);
        i_pmem_read = 1'b0; d_pmem_read = 1'b0;

        // D read and write together: write first, then the read for the same line
        d_pmem_read = 1'b1; d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_5000; d_pmem_wdata = {4{64'hDEAD_BEEF_CAFE_F00D}};
        txn(1'b1, 32'h0000_5000, {4{64'hDEAD_BEEF_CAFE_F00D}}, 1'b1, 3, 256'h55);
        d_pmem_write = 1'b0;
        txn(1'b0, 32'h0000_5000, '0, 1'b1, 3, {8{32'h0BAD_F00D}});
        d_pmem_read = 1'b0;
        step();

        // Reset two cycles into an I fill, then a late adaptor resp
        t = cyc;
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_6000;
        push_txn(1'b0, 32'h0000_6000, '0, t + 1);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0; i_pmem_read = 1'b0;
        step();
        pmem_resp = 1'b1; pmem_rdata = 256'h66;
        step();
        pmem_resp = 1'b0;
        step();

        // Stray resp while idle, then a normal fill still behaves
        pmem_resp = 1'b1; pmem_rdata = 256'h99;
        step();
        pmem_resp = 1'b0;
        step();
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_7000;
        txn(1'b0, 32'h0000_7000, '0, 1'b0, 2, {16{16'hC3C3}});
        i_pmem_read = 1'b0;
        step();
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of stimulus");
        $fatal(1, "timeout");
    end

endmodule
